// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants, types and helpers for the VGA bitmap overlay
package vga_pkg;

    // Active display area of the 640x480 mode
    localparam int H_ACT = 640;
    localparam int V_ACT = 480;

    // Configuration register addresses above the bitmap rows
    localparam logic [5:0] CFG_POS_X = 6'd32;
    localparam logic [5:0] CFG_POS_Y = 6'd33;
    localparam logic [5:0] CFG_SCALE = 6'd34;
    localparam logic [5:0] CFG_FG    = 6'd35;
    localparam logic [5:0] CFG_BG    = 6'd36;

    typedef enum logic [1:0] {
        SCALE_1X   = 2'd0,
        SCALE_2X   = 2'd1,
        SCALE_4X   = 2'd2,
        SCALE_RSVD = 2'd3
    } scale_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    localparam rgb24_t FG_RESET = 24'hFF0000;
    localparam rgb24_t BG_RESET = 24'h000000;

    // Left-shift amount for a scale code; the reserved code falls back to 1x
    function automatic logic [1:0] scale_shift(input scale_e s);
        return (s == SCALE_RSVD) ? 2'd0 : 2'(s);
    endfunction

endpackage

// File: rtl/vga_ovl_cfg.sv
// rtl/vga_ovl_cfg.sv - shadow/live geometry and colour registers with vsync-edge commit
module vga_ovl_cfg
    import vga_pkg::*;
#(
    parameter int COORD_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vs,
    input  logic               cfg_we,
    input  logic [5:0]         cfg_addr,
    input  logic [23:0]        cfg_wdata,
    output logic [COORD_W-1:0] o_pos_x,
    output logic [COORD_W-1:0] o_pos_y,
    output scale_e             o_scale,
    output rgb24_t             o_fg,
    output rgb24_t             o_bg
);

    logic               r_vs_d;
    logic               w_commit;

    logic [COORD_W-1:0] r_sh_pos_x;
    logic [COORD_W-1:0] r_sh_pos_y;
    scale_e             r_sh_scale;
    rgb24_t             r_sh_fg;
    rgb24_t             r_sh_bg;

    logic [COORD_W-1:0] r_lv_pos_x;
    logic [COORD_W-1:0] r_lv_pos_y;
    scale_e             r_lv_scale;
    rgb24_t             r_lv_fg;
    rgb24_t             r_lv_bg;

    // Previous in_vs; idles high so reset never looks like a falling edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vs_d <= 1'b1;
        end else begin
            r_vs_d <= in_vs;
        end
    end

    assign w_commit = r_vs_d & ~in_vs;

    // Host writes land in the shadow copies only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh_pos_x <= '0;
            r_sh_pos_y <= '0;
            r_sh_scale <= SCALE_1X;
            r_sh_fg    <= FG_RESET;
            r_sh_bg    <= BG_RESET;
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_POS_X: r_sh_pos_x <= cfg_wdata[COORD_W-1:0];
                CFG_POS_Y: r_sh_pos_y <= cfg_wdata[COORD_W-1:0];
                CFG_SCALE: r_sh_scale <= scale_e'(cfg_wdata[1:0]);
                CFG_FG:    r_sh_fg    <= cfg_wdata;
                CFG_BG:    r_sh_bg    <= cfg_wdata;
                default:   ;
            endcase
        end
    end

    // Live copies follow the shadows once per frame, so geometry is frame-stable;
    // a write on the commit edge is not seen here until the next frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lv_pos_x <= '0;
            r_lv_pos_y <= '0;
            r_lv_scale <= SCALE_1X;
            r_lv_fg    <= FG_RESET;
            r_lv_bg    <= BG_RESET;
        end else if (w_commit) begin
            r_lv_pos_x <= r_sh_pos_x;
            r_lv_pos_y <= r_sh_pos_y;
            r_lv_scale <= r_sh_scale;
            r_lv_fg    <= r_sh_fg;
            r_lv_bg    <= r_sh_bg;
        end
    end

    assign o_pos_x = r_lv_pos_x;
    assign o_pos_y = r_lv_pos_y;
    assign o_scale = r_lv_scale;
    assign o_fg    = r_lv_fg;
    assign o_bg    = r_lv_bg;

endmodule

// File: rtl/vga_bitmap_overlay.sv
// rtl/vga_bitmap_overlay.sv - 2-stage pixel pipeline drawing a scalable 1-bit bitmap; VGA_OVL_BORDER_EN adds a 1-pixel fg ring
module vga_bitmap_overlay
    import vga_pkg::*;
#(
    parameter int BMP_W   = 32,
    parameter int BMP_H   = 32,
    parameter int COORD_W = 11,
    parameter int COLOR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_hs,
    input  logic               in_vs,
    input  logic               in_blank_n,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic               cfg_we,
    input  logic [5:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b
);

    localparam int ROW_W = $clog2(BMP_H);
    localparam int COL_W = $clog2(BMP_W);
    localparam int EXT   = COORD_W + 2;

    // MSB-align an 8-bit channel onto the DAC width
    function automatic logic [COLOR_W-1:0] chan(input logic [7:0] c);
        logic [COLOR_W+7:0] t;
        t = {c, {COLOR_W{1'b0}}};
        return t[COLOR_W+7:8];
    endfunction

    logic [COORD_W-1:0] w_pos_x;
    logic [COORD_W-1:0] w_pos_y;
    scale_e             w_scale;
    rgb24_t             w_fg;
    rgb24_t             w_bg;

    vga_ovl_cfg #(
        .COORD_W (COORD_W)
    ) u_cfg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vs     (in_vs),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata[23:0]),
        .o_pos_x   (w_pos_x),
        .o_pos_y   (w_pos_y),
        .o_scale   (w_scale),
        .o_fg      (w_fg),
        .o_bg      (w_bg)
    );

    logic [BMP_W-1:0] r_bmp [BMP_H];

    // Bitmap rows are written directly; a same-cycle read still sees the old row
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BMP_H; i++) begin
                r_bmp[i] <= '0;
            end
        end else if (cfg_we && (cfg_addr < 6'(BMP_H))) begin
            r_bmp[cfg_addr[ROW_W-1:0]] <= cfg_wdata[BMP_W-1:0];
        end
    end

    // Window extent; all sums carry two extra bits so a window at the screen edge cannot wrap
    logic [1:0]         w_shift;
    logic [EXT-1:0]     w_win_w;
    logic [EXT-1:0]     w_win_h;
    logic [EXT-1:0]     w_x_ext;
    logic [EXT-1:0]     w_y_ext;
    logic [EXT-1:0]     w_px_ext;
    logic [EXT-1:0]     w_py_ext;
    logic [COORD_W:0]   w_dx;
    logic [COORD_W:0]   w_dy;
    logic               w_inside;

    assign w_shift  = scale_shift(w_scale);
    assign w_win_w  = EXT'(BMP_W) << w_shift;
    assign w_win_h  = EXT'(BMP_H) << w_shift;
    assign w_x_ext  = EXT'(in_x);
    assign w_y_ext  = EXT'(in_y);
    assign w_px_ext = EXT'(w_pos_x);
    assign w_py_ext = EXT'(w_pos_y);
    assign w_dx     = {1'b0, in_x} - {1'b0, w_pos_x};
    assign w_dy     = {1'b0, in_y} - {1'b0, w_pos_y};
    assign w_inside = (w_x_ext >= w_px_ext) && (w_x_ext < w_px_ext + w_win_w) &&
                      (w_y_ext >= w_py_ext) && (w_y_ext < w_py_ext + w_win_h);

    logic               r1_hs;
    logic               r1_vs;
    logic               r1_blank_n;
    logic               r1_inside;
    logic [ROW_W-1:0]   r1_row;
    logic [COL_W-1:0]   r1_col;

`ifdef VGA_OVL_BORDER_EN
    logic               w_near;
    logic               r1_border;

    // Window grown by one pixel on every side; the ring is this minus the window
    assign w_near = (w_x_ext + EXT'(1) >= w_px_ext) && (w_x_ext < w_px_ext + w_win_w + EXT'(1)) &&
                    (w_y_ext + EXT'(1) >= w_py_ext) && (w_y_ext < w_py_ext + w_win_h + EXT'(1));

    // Stage 1 border flag, aligned with the other stage 1 fields
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_border <= 1'b0;
        end else begin
            r1_border <= w_near && !w_inside;
        end
    end
`endif

    // Stage 1: capture timing and resolve window hit plus bitmap coordinates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_hs      <= 1'b1;
            r1_vs      <= 1'b1;
            r1_blank_n <= 1'b0;
            r1_inside  <= 1'b0;
            r1_row     <= '0;
            r1_col     <= '0;
        end else begin
            r1_hs      <= in_hs;
            r1_vs      <= in_vs;
            r1_blank_n <= in_blank_n;
            r1_inside  <= w_inside;
            r1_row     <= ROW_W'(w_dy >> w_shift);
            r1_col     <= COL_W'(w_dx >> w_shift);
        end
    end

    logic   w_bit;
    rgb24_t w_pix;

    assign w_bit = r_bmp[r1_row][COL_W'(BMP_W - 1) - r1_col];

    // Pixel colour selection: blank wins, then window fg/bg, then optional ring
    always_comb begin
        w_pix = '0;
        if (r1_blank_n) begin
            if (r1_inside) begin
                w_pix = w_bit ? w_fg : w_bg;
            end
`ifdef VGA_OVL_BORDER_EN
            else if (r1_border) begin
                w_pix = w_fg;
            end
`endif
        end
    end

    logic   r2_hs;
    logic   r2_vs;
    logic   r2_blank_n;
    rgb24_t r2_rgb;

    // Stage 2: output registers keep syncs, blank and colour aligned
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r2_hs      <= 1'b1;
            r2_vs      <= 1'b1;
            r2_blank_n <= 1'b0;
            r2_rgb     <= '0;
        end else begin
            r2_hs      <= r1_hs;
            r2_vs      <= r1_vs;
            r2_blank_n <= r1_blank_n;
            r2_rgb     <= w_pix;
        end
    end

    assign vga_hs      = r2_hs;
    assign vga_vs      = r2_vs;
    assign vga_blank_n = r2_blank_n;
    assign vga_r       = chan(r2_rgb.r);
    assign vga_g       = chan(r2_rgb.g);
    assign vga_b       = chan(r2_rgb.b);

endmodule
